// File: rtl/core_wb_pkg.sv
// +----------------------------------------------------------------------+
// | core_wb_pkg : shared types for the register-file write-back control  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package core_wb_pkg;

  localparam int N_REQ = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } wb_state_e;

  typedef enum logic [1:0] {
    REQ_ALU = 2'd0,
    REQ_LD  = 2'd1,
    REQ_IN  = 2'd2
  } req_id_e;

  function automatic req_id_e onehot_to_id(input logic [N_REQ-1:0] oh);
    if (oh[2])      return REQ_IN;
    else if (oh[1]) return REQ_LD;
    else            return REQ_ALU;
  endfunction

endpackage

`default_nettype wire

// File: rtl/core_wb_rr_arb.sv
// +----------------------------------------------------------------------+
// | core_wb_rr_arb : combinational 3-way round-robin / fixed arbiter     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module core_wb_rr_arb
  import core_wb_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  req_id_e          last_i,
  input  logic             rr_en_i,
  output logic [N_REQ-1:0] gnt_o
);

  logic [1:0] idx;
  logic       found;

  // Round-robin search begins just after the last grant; fixed mode starts at ALU.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = rr_en_i ? 2'((int'(last_i) + 1 + k) % N_REQ) : 2'(k);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/core_reg_wb_ctrl.sv
// +----------------------------------------------------------------------+
// | core_reg_wb_ctrl : register-file write-port arbiter with 2-cycle hold |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module core_reg_wb_ctrl
  import core_wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int RR_EN = 1
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            ALU_REQ,
  input  logic [AW-1:0]   ALU_ADDR,
  input  logic [XLEN-1:0] ALU_DATA,
  output logic            ALU_ACK,
  input  logic            LD_REQ,
  input  logic [AW-1:0]   LD_ADDR,
  input  logic [XLEN-1:0] LD_DATA,
  output logic            LD_ACK,
  input  logic            IN_REQ,
  input  logic [AW-1:0]   IN_ADDR,
  input  logic [7:0]      IN_DATA,
  output logic            IN_ACK,
  output logic [AW-1:0]   WADDR,
  output logic            WE,
  output logic [XLEN-1:0] WDATA,
  output logic            INE,
  output logic [7:0]      INDATA,
  output logic            BUSY,
  output logic [AW-1:0]   PEND_ADDR
);

  wb_state_e        state_q;
  req_id_e          last_q;
  logic [N_REQ-1:0] ack_q;
  logic [AW-1:0]    waddr_q;
  logic [XLEN-1:0]  wdata_q;
  logic [7:0]       indata_q;
  logic             we_q;
  logic             ine_q;

  logic [N_REQ-1:0] w_gnt;
  req_id_e          w_gid;
  logic [AW-1:0]    w_gaddr;

  core_wb_rr_arb u_arb (
    .req_i   ({IN_REQ, LD_REQ, ALU_REQ}),
    .last_i  (last_q),
    .rr_en_i (RR_EN != 0),
    .gnt_o   (w_gnt)
  );

  always_comb begin
    w_gid = onehot_to_id(w_gnt);
    case (w_gid)
      REQ_LD:  w_gaddr = LD_ADDR;
      REQ_IN:  w_gaddr = IN_ADDR;
      default: w_gaddr = ALU_ADDR;
    endcase
  end

  // last_q resets to IN so the first round-robin search after reset starts at ALU.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      last_q   <= REQ_IN;
      ack_q    <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      indata_q <= '0;
      we_q     <= 1'b0;
      ine_q    <= 1'b0;
    end else begin
      ack_q <= '0;
      we_q  <= 1'b0;
      ine_q <= 1'b0;
      case (state_q)
        ISSUE: state_q <= (waddr_q == '0) ? IDLE : HOLD;
        default: begin
          if (|w_gnt) begin
            state_q <= ISSUE;
            last_q  <= w_gid;
            ack_q   <= w_gnt;
            waddr_q <= w_gaddr;
            if (w_gid == REQ_IN) begin
              indata_q <= IN_DATA;
              ine_q    <= (w_gaddr != '0);
            end else begin
              wdata_q <= (w_gid == REQ_LD) ? LD_DATA : ALU_DATA;
              we_q    <= (w_gaddr != '0);
            end
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign ALU_ACK   = ack_q[0];
  assign LD_ACK    = ack_q[1];
  assign IN_ACK    = ack_q[2];
  assign WADDR     = waddr_q;
  assign WDATA     = wdata_q;
  assign INDATA    = indata_q;
  assign WE        = we_q;
  assign INE       = ine_q;
  assign BUSY      = (state_q != IDLE);
  assign PEND_ADDR = BUSY ? waddr_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_core_reg_wb_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_core_reg_wb_ctrl : directed bench for core_reg_wb_ctrl            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_core_reg_wb_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        ALU_REQ, LD_REQ, IN_REQ;
  logic [4:0]  ALU_ADDR, LD_ADDR, IN_ADDR;
  logic [31:0] ALU_DATA, LD_DATA;
  logic [7:0]  IN_DATA;

  logic        ALU_ACK, LD_ACK, IN_ACK, WE, INE, BUSY;
  logic [4:0]  WADDR, PEND_ADDR;
  logic [31:0] WDATA;
  logic [7:0]  INDATA;

  logic        f_ALU_ACK, f_LD_ACK, f_IN_ACK, f_WE, f_INE, f_BUSY;
  logic [4:0]  f_WADDR, f_PEND_ADDR;
  logic [31:0] f_WDATA;
  logic [7:0]  f_INDATA;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  core_reg_wb_ctrl #(.XLEN(32), .AW(5), .RR_EN(1)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .ALU_REQ(ALU_REQ), .ALU_ADDR(ALU_ADDR), .ALU_DATA(ALU_DATA), .ALU_ACK(ALU_ACK),
    .LD_REQ(LD_REQ), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA), .LD_ACK(LD_ACK),
    .IN_REQ(IN_REQ), .IN_ADDR(IN_ADDR), .IN_DATA(IN_DATA), .IN_ACK(IN_ACK),
    .WADDR(WADDR), .WE(WE), .WDATA(WDATA), .INE(INE), .INDATA(INDATA),
    .BUSY(BUSY), .PEND_ADDR(PEND_ADDR)
  );

  core_reg_wb_ctrl #(.XLEN(32), .AW(5), .RR_EN(0)) dut_fp (
    .CLK(CLK), .RST_N(RST_N),
    .ALU_REQ(ALU_REQ), .ALU_ADDR(ALU_ADDR), .ALU_DATA(ALU_DATA), .ALU_ACK(f_ALU_ACK),
    .LD_REQ(LD_REQ), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA), .LD_ACK(f_LD_ACK),
    .IN_REQ(IN_REQ), .IN_ADDR(IN_ADDR), .IN_DATA(IN_DATA), .IN_ACK(f_IN_ACK),
    .WADDR(f_WADDR), .WE(f_WE), .WDATA(f_WDATA), .INE(f_INE), .INDATA(f_INDATA),
    .BUSY(f_BUSY), .PEND_ADDR(f_PEND_ADDR)
  );

  typedef struct {
    int          kind;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [2:0]  ack;
    logic        we;
    logic        ine;
    logic [31:0] wdata;
    logic [7:0]  indata;
    logic        hold;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int kind, input logic on, input logic [4:0] addr,
                         input logic [31:0] data);
    case (kind)
      0: begin ALU_REQ = on; ALU_ADDR = addr; ALU_DATA = data; end
      1: begin LD_REQ = on; LD_ADDR = addr; LD_DATA = data; end
      default: begin IN_REQ = on; IN_ADDR = addr; IN_DATA = data[7:0]; end
    endcase
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    ALU_REQ = 0; LD_REQ = 0; IN_REQ = 0;
    step();
    step();
    RST_N = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int alu_n, ld_n, in_n, alu_c, ld_c, in_c, fp_alu, fp_ld, rr_ld;
    logic [15:0] we_bits, ine_bits;
    logic seen;

    // kind addr data ack we ine wdata indata hold
    tbl[0] = '{0, 5'd5,  32'hDEADBEEF, 3'b001, 1, 0, 32'hDEADBEEF, 8'h00, 1};
    tbl[1] = '{2, 5'd7,  32'h00000041, 3'b100, 0, 1, 32'hDEADBEEF, 8'h41, 1};
    tbl[2] = '{1, 5'd0,  32'h12345678, 3'b010, 0, 0, 32'h12345678, 8'h41, 0};
    tbl[3] = '{1, 5'd31, 32'hCAFEF00D, 3'b010, 1, 0, 32'hCAFEF00D, 8'h41, 1};
    tbl[4] = '{2, 5'd0,  32'h00000099, 3'b100, 0, 0, 32'hCAFEF00D, 8'h99, 0};
    tbl[5] = '{0, 5'd16, 32'h00000001, 3'b001, 1, 0, 32'h00000001, 8'h99, 1};

    ALU_ADDR = 0; ALU_DATA = 0; LD_ADDR = 0; LD_DATA = 0; IN_ADDR = 0; IN_DATA = 0;
    do_reset();
    chk("reset_outputs", {WE, INE, BUSY, ALU_ACK, LD_ACK, IN_ACK, WADDR, PEND_ADDR}, 0);
    chk("reset_wdata", WDATA, 0);
    chk("reset_indata", {24'h0, INDATA}, 0);

    // Single-requester transactions: ISSUE cycle, optional HOLD, back to IDLE.
    for (int i = 0; i < 6; i++) begin
      set_req(tbl[i].kind, 1'b1, tbl[i].addr, tbl[i].data);
      step();
      chk($sformatf("v%0d_ack", i), {29'h0, IN_ACK, LD_ACK, ALU_ACK}, {29'h0, tbl[i].ack});
      chk($sformatf("v%0d_we_ine", i), {30'h0, WE, INE}, {30'h0, tbl[i].we, tbl[i].ine});
      chk($sformatf("v%0d_waddr", i), {27'h0, WADDR}, {27'h0, tbl[i].addr});
      chk($sformatf("v%0d_wdata", i), WDATA, tbl[i].wdata);
      chk($sformatf("v%0d_indata", i), {24'h0, INDATA}, {24'h0, tbl[i].indata});
      chk($sformatf("v%0d_busy_pend", i), {26'h0, BUSY, PEND_ADDR}, {26'h0, 1'b1, tbl[i].addr});
      set_req(tbl[i].kind, 1'b0, tbl[i].addr, tbl[i].data);
      step();
      if (tbl[i].hold) begin
        chk($sformatf("v%0d_hold_strobes", i), {29'h0, WE, INE, BUSY}, 32'h1);
        chk($sformatf("v%0d_hold_waddr", i), {27'h0, WADDR}, {27'h0, tbl[i].addr});
        chk($sformatf("v%0d_hold_wdata", i), WDATA, tbl[i].wdata);
        chk($sformatf("v%0d_hold_indata", i), {24'h0, INDATA}, {24'h0, tbl[i].indata});
        step();
      end
      chk($sformatf("v%0d_idle", i), {26'h0, BUSY, PEND_ADDR}, 0);
    end

    // All three at once, round-robin from reset: ALU, LD, IN two cycles apart.
    do_reset();
    set_req(0, 1, 5'd1, 32'hA1A1A1A1);
    set_req(1, 1, 5'd2, 32'hB2B2B2B2);
    set_req(2, 1, 5'd3, 32'h0000003C);
    alu_n = 0; ld_n = 0; in_n = 0; alu_c = 0; ld_c = 0; in_c = 0;
    we_bits = '0; ine_bits = '0;
    for (int c = 1; c <= 10; c++) begin
      step();
      we_bits[c] = WE;
      ine_bits[c] = INE;
      if (ALU_ACK) begin alu_n++; alu_c = c; ALU_REQ = 0; end
      if (LD_ACK) begin
        ld_n++; ld_c = c; LD_REQ = 0;
        chk("rr_ld_waddr_wdata", {WADDR, WDATA[26:0]}, {5'd2, 27'h2B2B2B2});
      end
      if (IN_ACK) begin
        in_n++; in_c = c; IN_REQ = 0;
        chk("rr_in_waddr_indata", {19'h0, WADDR, INDATA}, {19'h0, 5'd3, 8'h3C});
      end
    end
    chk("rr_ack_counts", {alu_n[7:0], ld_n[7:0], in_n[7:0]}, 32'h010101);
    chk("rr_ack_cycles", {alu_c[7:0], ld_c[7:0], in_c[7:0]}, 32'h010305);
    chk("rr_we_cycles", {16'h0, we_bits}, 32'h000A);
    chk("rr_ine_cycles", {16'h0, ine_bits}, 32'h0020);

    // Fixed priority: ALU held keeps winning; round-robin instance interleaves LD.
    do_reset();
    set_req(0, 1, 5'd4, 32'h44444444);
    set_req(1, 1, 5'd6, 32'h66666666);
    fp_alu = 0; fp_ld = 0; rr_ld = 0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (f_ALU_ACK) fp_alu++;
      if (f_LD_ACK) fp_ld++;
      if (LD_ACK) rr_ld++;
    end
    chk("fp_alu_acks", fp_alu, 4);
    chk("fp_ld_starved", fp_ld, 0);
    chk("rr_ld_interleaved", rr_ld, 2);
    ALU_REQ = 0;
    seen = 1'b0;
    for (int c = 0; c < 4 && !seen; c++) begin
      step();
      if (f_LD_ACK) begin
        seen = 1'b1;
        chk("fp_ld_after_drop_waddr", {27'h0, f_WADDR}, 32'd6);
        chk("fp_ld_after_drop_we", {31'h0, f_WE}, 1);
      end
    end
    chk("fp_ld_served", {31'h0, seen}, 1);
    LD_REQ = 0;
    step(); step(); step();

    // Reset during HOLD drops the latched write; a waiting LD is served after release.
    do_reset();
    set_req(0, 1, 5'd9, 32'h99999999);
    step();
    chk("rst_issue", {29'h0, ALU_ACK, WE, BUSY}, 32'h7);
    ALU_REQ = 0;
    set_req(1, 1, 5'd12, 32'h0BADF00D);
    step();
    chk("rst_in_hold", {27'h0, WE, BUSY, LD_ACK, 2'b00} | {27'h0, WADDR}, {27'h0, 5'b01000} | 32'd9);
    RST_N = 0;
    step();
    chk("rst_outputs", {WE, INE, BUSY, ALU_ACK, LD_ACK, IN_ACK, WADDR, PEND_ADDR}, 0);
    chk("rst_data", {WDATA[23:0], INDATA}, 0);
    RST_N = 1;
    step();
    chk("rst_reserve", {25'h0, LD_ACK, WE, WADDR}, {25'h0, 1'b1, 1'b1, 5'd12});
    chk("rst_reserve_data", WDATA, 32'h0BADF00D);
    LD_REQ = 0;
    step(); step();
    chk("rst_final_idle", {31'h0, BUSY}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
